// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, oversample rate and frame defaults.
package uart_pkg;

   localparam int unsigned OVERSAMPLE  = 16;
   localparam int unsigned DBIT_DEF    = 8;
   localparam int unsigned SB_TICK_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_START = 2'b01,
      ST_DATA  = 2'b10,
      ST_STOP  = 2'b11
   } tx_state_e;

   // Counter width able to hold n-1, never narrower than min_w.
   function automatic int unsigned cnt_width(input int unsigned n, input int unsigned min_w);
      int unsigned w;
      w = $clog2(n);
      return (w < min_w) ? min_w : w;
   endfunction

endpackage

// File: rtl/uart_tx_right_piso_reg.sv
// Parallel-load, right-shift register; transmit-side twin of the receive SIPO.
module right_piso_reg
   import uart_pkg::*;
#(
   parameter int unsigned W = DBIT_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         lsb,
   output logic         lsb_next
);

   logic [W-1:0] q;

   // Load has priority; a shift fills zeros from the top.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (load) begin
         q <= din;
      end else if (shift) begin
         q <= {1'b0, q[W-1:1]};
      end
   end

   // lsb_next lets the line flop pick up the following bit on the shift edge.
   assign lsb      = q[0];
   assign lsb_next = q[1];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB-first, SB_TICK-tick stop period.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DBIT    = DBIT_DEF,
   parameter int unsigned SB_TICK = SB_TICK_DEF
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            s_tick,
   input  logic            tx_start,
   input  logic [DBIT-1:0] tx_din,
   output logic            tx_busy,
   output logic            tx_done_tick,
   output logic            tx
);

   localparam int unsigned S_W = cnt_width(SB_TICK, 4);
   localparam int unsigned N_W = cnt_width(DBIT, 1);

   tx_state_e        state_q, state_d;
   logic [S_W-1:0]   s_cnt_q, s_cnt_d;
   logic [N_W-1:0]   n_cnt_q, n_cnt_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;
   logic             busy_q;
   logic             load, shift;
   logic             lsb, lsb_next;

   right_piso_reg #(.W(DBIT)) u_piso (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load),
      .shift    (shift),
      .din      (tx_din),
      .lsb      (lsb),
      .lsb_next (lsb_next)
   );

   // State, counters and the line/done/busy flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         s_cnt_q <= '0;
         n_cnt_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_cnt_q <= s_cnt_d;
         n_cnt_q <= n_cnt_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   // Next-state, counter and next line-level logic.
   always_comb begin
      state_d = state_q;
      s_cnt_d = s_cnt_q;
      n_cnt_d = n_cnt_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      load    = 1'b0;
      shift   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (tx_start) begin
               load    = 1'b1;
               s_cnt_d = '0;
               state_d = ST_START;
               tx_d    = 1'b0;
            end
         end

         ST_START: begin
            tx_d = 1'b0;
            if (s_tick) begin
               if (s_cnt_q == S_W'(OVERSAMPLE - 1)) begin
                  s_cnt_d = '0;
                  n_cnt_d = '0;
                  state_d = ST_DATA;
                  tx_d    = lsb;
               end else begin
                  s_cnt_d = s_cnt_q + S_W'(1);
               end
            end
         end

         ST_DATA: begin
            tx_d = lsb;
            if (s_tick) begin
               if (s_cnt_q == S_W'(OVERSAMPLE - 1)) begin
                  s_cnt_d = '0;
                  shift   = 1'b1;
                  if (n_cnt_q == N_W'(DBIT - 1)) begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end else begin
                     n_cnt_d = n_cnt_q + N_W'(1);
                     tx_d    = lsb_next;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + S_W'(1);
               end
            end
         end

         ST_STOP: begin
            tx_d = 1'b1;
            if (s_tick) begin
               if (s_cnt_q == S_W'(SB_TICK - 1)) begin
                  s_cnt_d = '0;
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  s_cnt_d = s_cnt_q + S_W'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign tx           = tx_q;
   assign tx_done_tick = done_q;
   assign tx_busy      = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: an 8N1 instance and a 7-bit / 2-stop instance.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       s_tick;
   logic       tick_en;
   logic       tx_start0, tx_start1;
   logic [7:0] din0;
   logic [6:0] din1;
   logic       busy0, busy1, done0, done1, tx0, tx1;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [8:0] q0[$];
   logic [8:0] q1[$];

   bit         in_frame [2];
   bit         prev_tx  [2];
   int         tcnt     [2];
   logic [8:0] data     [2];
   int         done_cyc [2];
   bit         b2b_mode;

   uart_tx #(.DBIT(8), .SB_TICK(16)) dut0 (
      .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start0),
      .tx_din(din0), .tx_busy(busy0), .tx_done_tick(done0), .tx(tx0));

   uart_tx #(.DBIT(7), .SB_TICK(32)) dut1 (
      .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start1),
      .tx_din(din1), .tx_busy(busy1), .tx_done_tick(done1), .tx(tx1));

   always #5 clk = ~clk;

   // s_tick every 4th clk, changed just after posedge so it is stable at negedge.
   initial begin
      int c;
      c = 0;
      s_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_en) begin
            c = (c + 1) % 4;
            s_tick = (c == 0);
         end else begin
            s_tick = 1'b0;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Decode one channel's serial line for the current negedge.
   task automatic mon_step(input int i);
      bit         t, d, b;
      int         nb, tot, k;
      logic [8:0] e;
      t   = (i == 0) ? tx0 : tx1;
      d   = (i == 0) ? done0 : done1;
      b   = (i == 0) ? busy0 : busy1;
      nb  = (i == 0) ? 8 : 7;
      tot = (i == 0) ? 16 * 9 + 16 : 16 * 8 + 32;
      if (!reset_n) begin
         in_frame[i] = 0;
         prev_tx[i]  = 1;
         return;
      end
      if (!in_frame[i]) begin
         if (d) check($sformatf("spurious_done_ch%0d", i), 1, 0);
         if (prev_tx[i] && !t) begin
            in_frame[i] = 1;
            tcnt[i]     = 0;
            data[i]     = '0;
            if (b2b_mode && i == 0) check("idle_gap_clk", cyc - done_cyc[i], 1);
         end
      end
      if (in_frame[i]) begin
         if (d) begin
            check($sformatf("frame_ticks_ch%0d", i), tcnt[i], tot);
            check($sformatf("line_high_at_done_ch%0d", i), int'(t), 1);
            if (((i == 0) ? q0.size() : q1.size()) == 0) begin
               check($sformatf("unexpected_frame_ch%0d", i), int'(data[i]), -1);
            end else begin
               e = (i == 0) ? q0.pop_front() : q1.pop_front();
               check($sformatf("frame_data_ch%0d", i), int'(data[i]), int'(e));
            end
            in_frame[i] = 0;
            done_cyc[i] = cyc;
         end else if (s_tick) begin
            tcnt[i]++;
            if (tcnt[i] % 16 == 8) begin
               k = tcnt[i] / 16;
               if (k == 0) begin
                  check($sformatf("start_bit_ch%0d", i), int'(t), 0);
                  check($sformatf("busy_in_frame_ch%0d", i), int'(b), 1);
               end else if (k <= nb) begin
                  data[i][k-1] = t;
               end else begin
                  check($sformatf("stop_level_ch%0d", i), int'(t), 1);
               end
            end
         end
      end
      prev_tx[i] = t;
   endtask

   task automatic run_monitor();
      forever begin
         @(negedge clk);
         cyc++;
         mon_step(0);
         mon_step(1);
      end
   endtask

   task automatic wait_done(input int ch, input int budget);
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if ((ch == 0) ? done0 : done1) return;
      end
      check($sformatf("done_timeout_ch%0d", ch), 0, 1);
   endtask

   task automatic pulse0(input logic [7:0] v);
      @(negedge clk);
      din0 = v;
      tx_start0 = 1'b1;
      q0.push_back({1'b0, v});
      @(negedge clk);
      tx_start0 = 1'b0;
   endtask

   initial begin
      int bad;
      bit hold;
      reset_n   = 1'b0;
      tick_en   = 1'b1;
      tx_start0 = 1'b0;
      tx_start1 = 1'b0;
      din0      = '0;
      din1      = '0;
      b2b_mode  = 0;
      for (int i = 0; i < 2; i++) begin
         in_frame[i] = 0; prev_tx[i] = 1; tcnt[i] = 0; data[i] = '0; done_cyc[i] = 0;
      end
      fork
         run_monitor();
      join_none

      // Reset values, then a quiet idle period.
      repeat (3) @(negedge clk);
      check("reset_tx", int'(tx0), 1);
      check("reset_busy", int'(busy0), 0);
      check("reset_done", int'(done0), 0);
      reset_n = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) bad++;
      end
      check("idle_after_reset_bad_cycles", bad, 0);

      // Single 8'hA5 frame with 1-clk acceptance latency.
      @(negedge clk);
      din0 = 8'hA5;
      tx_start0 = 1'b1;
      q0.push_back(9'h0A5);
      @(negedge clk);
      tx_start0 = 1'b0;
      check("fall_latency_tx", int'(tx0), 0);
      check("busy_on_accept", int'(busy0), 1);
      wait_done(0, 2000);
      @(negedge clk);
      check("busy_after_done", int'(busy0), 0);
      check("done_one_clk", int'(done0), 0);
      repeat (10) @(negedge clk);

      // Held tx_start: 00/FF alternating back-to-back; din changed mid-frame.
      @(negedge clk);
      din0 = 8'h00;
      tx_start0 = 1'b1;
      q0.push_back(9'h000);
      repeat (10) @(negedge clk);
      b2b_mode = 1;
      repeat (100) @(negedge clk);
      din0 = 8'hFF;
      for (int f = 0; f < 3; f++) begin
         wait_done(0, 2000);
         din0 = (f % 2 == 0) ? 8'hFF : 8'h00;
         q0.push_back({1'b0, din0});
      end
      wait_done(0, 2000);
      tx_start0 = 1'b0;
      b2b_mode  = 0;
      repeat (20) @(negedge clk);
      check("b2b_end_idle", int'(busy0), 0);

      // 8'h81 frame; a 3C request mid-DATA is ignored; ticks paused mid-frame.
      pulse0(8'h81);
      repeat (300) @(negedge clk);
      din0 = 8'h3C;
      tx_start0 = 1'b1;
      @(negedge clk);
      tx_start0 = 1'b0;
      tick_en = 1'b0;
      repeat (2) @(negedge clk);
      hold = tx0;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx0 !== hold) bad++;
      end
      check("line_hold_without_tick", bad, 0);
      check("busy_hold_without_tick", int'(busy0), 1);
      tick_en = 1'b1;
      wait_done(0, 2000);
      repeat (200) @(negedge clk);
      check("no_second_frame_busy", int'(busy0), 0);
      check("no_second_frame_queue", q0.size(), 0);

      // Reset during data bit 3 truncates the frame; 8'h55 then sends cleanly.
      pulse0(8'hC3);
      repeat (280) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("async_reset_tx", int'(tx0), 1);
      check("async_reset_busy", int'(busy0), 0);
      check("async_reset_done", int'(done0), 0);
      q0.delete();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      check("post_reset_idle_tx", int'(tx0), 1);
      pulse0(8'h55);
      wait_done(0, 2000);

      // 7-bit, 2-stop-bit instance sends 7'h41.
      @(negedge clk);
      din1 = 7'h41;
      tx_start1 = 1'b1;
      q1.push_back(9'h041);
      @(negedge clk);
      tx_start1 = 1'b0;
      check("ch1_fall_latency", int'(tx1), 0);
      wait_done(1, 3000);
      repeat (20) @(negedge clk);
      check("ch1_queue_drained", q1.size(), 0);
      check("ch0_queue_drained", q0.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
